// File: rtl/ps2_keys_pkg.sv
// Shared PS/2 set-2 scancodes and Digger heading encoding for the key decoder.
package ps2_keys_pkg;

    localparam logic [7:0] KEY_W     = 8'h1D;
    localparam logic [7:0] KEY_S     = 8'h1B;
    localparam logic [7:0] KEY_A     = 8'h1C;
    localparam logic [7:0] KEY_D     = 8'h23;
    localparam logic [7:0] KEY_ESC   = 8'h76;
    localparam logic [7:0] KEY_SPACE = 8'h29;
    localparam logic [7:0] KEY_P     = 8'h4D;
    localparam logic [7:0] KEY_ENTER = 8'h5A;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    // Only meaningful for the four movement keys; anything else maps to up.
    function automatic dir_t key_dir(input logic [7:0] code);
        dir_t d;
        case (code)
            KEY_S:   d = DIR_DOWN;
            KEY_A:   d = DIR_LEFT;
            KEY_D:   d = DIR_RIGHT;
            default: d = DIR_UP;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Key input and game-command outputs between the scancode receiver, the decoder and game logic.
interface ps2_key_decoder_if;

    logic [7:0]         key_code;
    logic               key_sample;
    ps2_keys_pkg::dir_t dir;
    logic               moving;
    logic               step;
    logic               fire;
    logic               paused;
    logic               start;
    logic               key_valid;
    logic [7:0]         last_code;

    modport master (
        output key_code, key_sample,
        input  dir, moving, step, fire, paused, start, key_valid, last_code
    );

    modport slave (
        input  key_code, key_sample,
        output dir, moving, step, fire, paused, start, key_valid, last_code
    );

endinterface

// File: rtl/ps2_key_decoder_sync.sv
// Brings the asynchronous key_sample strobe into the clk domain and flags one event per rising edge.
module ps2_event_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_sample,
    input  logic [7:0] key_code,
    output logic       key_event,
    output logic [7:0] code
);

    logic sync1;
    logic sync2;
    logic sync3;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= key_sample;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign key_event = sync2 & ~sync3;
    // key_code has been stable for at least two clocks by the time key_event fires.
    assign code      = key_code;

endmodule

// File: rtl/ps2_key_decoder.sv
// Decodes captured scancodes into Digger commands and paces movement steps and fire rate.
module ps2_key_decoder
    import ps2_keys_pkg::*;
#(
    parameter int STEP_DIV      = 5000000,
    parameter int FIRE_COOLDOWN = 25000000
) (
    input logic              clk,
    input logic              rst,
    ps2_key_decoder_if.slave bus
);

    localparam int STEP_W = $clog2(STEP_DIV);
    localparam int COOL_W = $clog2(FIRE_COOLDOWN + 1);
    localparam logic [STEP_W-1:0] STEP_RELOAD = STEP_W'(STEP_DIV - 1);
    localparam logic [COOL_W-1:0] COOL_LOAD   = COOL_W'(FIRE_COOLDOWN);

    logic              key_event;
    logic [7:0]        code;
    logic [STEP_W-1:0] step_cnt;
    logic [COOL_W-1:0] cooldown;

    ps2_event_sync u_sync (
        .clk        (clk),
        .rst        (rst),
        .key_sample (bus.key_sample),
        .key_code   (bus.key_code),
        .key_event  (key_event),
        .code       (code)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.dir       <= DIR_UP;
            bus.moving    <= 1'b0;
            bus.step      <= 1'b0;
            bus.fire      <= 1'b0;
            bus.paused    <= 1'b0;
            bus.start     <= 1'b0;
            bus.key_valid <= 1'b0;
            bus.last_code <= 8'h00;
            step_cnt      <= '0;
            cooldown      <= '0;
        end else begin
            bus.key_valid <= 1'b0;
            bus.step      <= 1'b0;
            bus.fire      <= 1'b0;
            bus.start     <= 1'b0;

            if (cooldown != '0)
                cooldown <= cooldown - COOL_W'(1);

            if (bus.moving && !bus.paused) begin
                if (step_cnt == '0) begin
                    bus.step <= 1'b1;
                    step_cnt <= STEP_RELOAD;
                end else begin
                    step_cnt <= step_cnt - STEP_W'(1);
                end
            end

            // Key handling comes last so a direction key overrides the timer and yields one step.
            if (key_event) begin
                bus.key_valid <= 1'b1;
                bus.last_code <= code;
                case (code)
                    KEY_W, KEY_S, KEY_A, KEY_D: begin
                        bus.dir    <= key_dir(code);
                        bus.moving <= 1'b1;
                        if (!bus.paused) begin
                            bus.step <= 1'b1;
                            step_cnt <= STEP_RELOAD;
                        end
                    end
                    KEY_ESC: bus.moving <= 1'b0;
                    KEY_SPACE: begin
                        if (cooldown == '0 && !bus.paused) begin
                            bus.fire <= 1'b1;
                            cooldown <= COOL_LOAD;
                        end
                    end
                    KEY_P: bus.paused <= ~bus.paused;
                    KEY_ENTER: begin
                        bus.start  <= 1'b1;
                        bus.paused <= 1'b0;
                        bus.moving <= 1'b0;
                        bus.dir    <= DIR_UP;
                        cooldown   <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: per-feature scenario tasks against a cycle-level behavioural model.
module tb_ps2_key_decoder;

    localparam int STEP_DIV      = 4;
    localparam int FIRE_COOLDOWN = 8;

    typedef struct {
        logic [7:0] code;
        int         hold;
        int         gap;
    } req_t;

    typedef struct {
        longint     at;
        logic [7:0] code;
    } ev_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;

    req_t req_q[$];
    ev_t  ev_q[$];
    bit   drv_busy = 1'b0;

    logic [1:0] m_dir;
    bit         m_moving, m_step, m_fire, m_paused, m_start, m_valid;
    logic [7:0] m_last;
    int         m_rem;
    longint     m_last_fire;

    always #5 clk = ~clk;

    ps2_key_decoder_if bus ();

    ps2_key_decoder #(
        .STEP_DIV      (STEP_DIV),
        .FIRE_COOLDOWN (FIRE_COOLDOWN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Keystroke driver: holds key_sample for 'hold' clocks, then at least one clock low.
    initial begin
        bus.key_code   = 8'h00;
        bus.key_sample = 1'b0;
        forever begin
            @(posedge clk);
            if (req_q.size() != 0) begin
                req_t r;
                ev_t  e;
                r = req_q.pop_front();
                drv_busy = 1'b1;
                repeat (r.gap) @(posedge clk);
                #1;
                bus.key_code   = r.code;
                bus.key_sample = 1'b1;
                e.at   = cyc + 3;
                e.code = r.code;
                ev_q.push_back(e);
                repeat (r.hold) @(posedge clk);
                #1;
                bus.key_sample = 1'b0;
                drv_busy = 1'b0;
            end
        end
    end

    // Reference model: m_rem is the number of active (moving, unpaused) cycles until the next step;
    // fire acceptance uses the distance in cycles from the last accepted fire.
    always @(posedge clk) begin
        bit  active;
        ev_t e;
        cyc++;
        if (rst) begin
            m_dir = 2'b00; m_moving = 0; m_step = 0; m_fire = 0; m_paused = 0;
            m_start = 0; m_valid = 0; m_last = 8'h00; m_rem = 1; m_last_fire = -1000;
            ev_q.delete();
        end else begin
            active  = m_moving && !m_paused;
            m_step  = 0; m_fire = 0; m_start = 0; m_valid = 0;
            if (active) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_step = 1;
                    m_rem  = STEP_DIV;
                end
            end
            if (ev_q.size() != 0 && ev_q[0].at == cyc) begin
                e = ev_q.pop_front();
                m_valid = 1;
                m_last  = e.code;
                if (e.code == 8'h1D || e.code == 8'h1B || e.code == 8'h1C || e.code == 8'h23) begin
                    m_dir = (e.code == 8'h1D) ? 2'b00 : (e.code == 8'h1B) ? 2'b01 :
                            (e.code == 8'h1C) ? 2'b10 : 2'b11;
                    m_moving = 1;
                    if (!m_paused) begin
                        m_step = 1;
                        m_rem  = STEP_DIV;
                    end
                end else if (e.code == 8'h76) begin
                    m_moving = 0;
                end else if (e.code == 8'h29) begin
                    if (!m_paused && (cyc - m_last_fire) >= FIRE_COOLDOWN + 1) begin
                        m_fire      = 1;
                        m_last_fire = cyc;
                    end
                end else if (e.code == 8'h4D) begin
                    m_paused = !m_paused;
                end else if (e.code == 8'h5A) begin
                    m_start = 1; m_paused = 0; m_moving = 0; m_dir = 2'b00;
                    m_last_fire = -1000;
                end
            end
        end
    end

    function automatic logic [15:0] observed();
        return {bus.dir, bus.moving, bus.step, bus.fire, bus.paused, bus.start, bus.key_valid, bus.last_code};
    endfunction

    function automatic logic [15:0] expected();
        return {m_dir, m_moving, m_step, m_fire, m_paused, m_start, m_valid, m_last};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("[TB] FAIL reset_model cycle %0d: got %h expected %h", cyc, observed(), expected());
            end
            checks++;
            if (observed() !== 16'h0000) begin
                errors++;
                $display("[TB] FAIL reset_idle cycle %0d: got %h expected 0000", cyc, observed());
            end
        end
    endtask

    task automatic test_direction();
        int tail = 0;
        int steps = 0;
        req_q.push_back('{8'h23, 3, 0});
        for (int i = 0; i < 400 && tail < 24; i++) begin
            @(negedge clk);
            steps += int'(bus.step);
            if (req_q.size() == 0 && !drv_busy) tail++;
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("[TB] FAIL direction cycle %0d: got %h expected %h", cyc, observed(), expected());
            end
        end
        checks++;
        if (tail < 24 || steps < 6) begin
            errors++;
            $display("[TB] FAIL direction_steps: got %0d steps (tail %0d) required at least 6", steps, tail);
        end
    endtask

    task automatic test_pause();
        int tail = 0;
        req_q.push_back('{8'h4D, 3, 2});
        req_q.push_back('{8'h4D, 3, 9});
        req_q.push_back('{8'h76, 3, 6});
        for (int i = 0; i < 400 && tail < 16; i++) begin
            @(negedge clk);
            if (req_q.size() == 0 && !drv_busy) tail++;
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("[TB] FAIL pause cycle %0d: got %h expected %h", cyc, observed(), expected());
            end
        end
        checks++;
        if (tail < 16 || bus.moving !== 1'b0 || bus.paused !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pause_end: got moving %b paused %b required 0 0", bus.moving, bus.paused);
        end
    endtask

    task automatic test_fire();
        int tail = 0;
        int fires = 0;
        req_q.push_back('{8'h29, 3, 0});
        req_q.push_back('{8'h29, 3, 1});
        req_q.push_back('{8'h29, 3, 0});
        req_q.push_back('{8'h4D, 3, 10});
        req_q.push_back('{8'h29, 3, 10});
        req_q.push_back('{8'h4D, 3, 0});
        for (int i = 0; i < 600 && tail < 12; i++) begin
            @(negedge clk);
            fires += int'(bus.fire);
            if (req_q.size() == 0 && !drv_busy) tail++;
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("[TB] FAIL fire cycle %0d: got %h expected %h", cyc, observed(), expected());
            end
        end
        checks++;
        if (fires !== 2) begin
            errors++;
            $display("[TB] FAIL fire_count: got %0d pulses required 2", fires);
        end
    endtask

    task automatic test_hold();
        int tail = 0;
        int valids = 0;
        req_q.push_back('{8'h1D, 50, 0});
        req_q.push_back('{8'h42, 3, 2});
        for (int i = 0; i < 600 && tail < 8; i++) begin
            @(negedge clk);
            valids += int'(bus.key_valid);
            if (req_q.size() == 0 && !drv_busy) tail++;
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("[TB] FAIL hold cycle %0d: got %h expected %h", cyc, observed(), expected());
            end
        end
        checks++;
        if (valids !== 2 || bus.last_code !== 8'h42 || bus.dir !== 2'b00 || bus.moving !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hold_end: got valids %0d last %h dir %b moving %b required 2 42 00 1",
                     valids, bus.last_code, bus.dir, bus.moving);
        end
    endtask

    task automatic test_start();
        int tail = 0;
        int fires = 0;
        int starts = 0;
        req_q.push_back('{8'h23, 3, 0});
        req_q.push_back('{8'h29, 3, 0});
        req_q.push_back('{8'h5A, 3, 0});
        req_q.push_back('{8'h29, 3, 0});
        for (int i = 0; i < 400 && tail < 8; i++) begin
            @(negedge clk);
            fires  += int'(bus.fire);
            starts += int'(bus.start);
            if (req_q.size() == 0 && !drv_busy) tail++;
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("[TB] FAIL start cycle %0d: got %h expected %h", cyc, observed(), expected());
            end
        end
        checks++;
        if (fires !== 2 || starts !== 1 || bus.moving !== 1'b0 || bus.dir !== 2'b00) begin
            errors++;
            $display("[TB] FAIL start_end: got fires %0d starts %0d moving %b dir %b required 2 1 0 00",
                     fires, starts, bus.moving, bus.dir);
        end
    endtask

    task automatic test_random();
        logic [7:0] codes [9] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h76, 8'h29, 8'h4D, 8'h5A, 8'h00};
        int tail = 0;
        for (int k = 0; k < 60; k++) begin
            req_t r;
            int sel;
            sel = int'($urandom_range(0, 8));
            r.code = (sel == 8) ? 8'($urandom) : codes[sel];
            r.hold = int'($urandom_range(3, 6));
            r.gap  = int'($urandom_range(0, 10));
            req_q.push_back(r);
        end
        for (int i = 0; i < 4000 && tail < 10; i++) begin
            @(negedge clk);
            if (req_q.size() == 0 && !drv_busy) tail++;
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("[TB] FAIL random cycle %0d: got %h expected %h", cyc, observed(), expected());
            end
        end
        checks++;
        if (tail < 10) begin
            errors++;
            $display("[TB] FAIL random_drain: got %0d pending requests required 0", req_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int tail = 0;
        req_q.push_back('{8'h1C, 3, 0});
        for (int i = 0; i < 200 && tail < 2; i++) begin
            @(negedge clk);
            if (req_q.size() == 0 && !drv_busy) tail++;
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("[TB] FAIL reset_mid_pre cycle %0d: got %h expected %h", cyc, observed(), expected());
            end
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (observed() !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset_mid: got %h expected 0000", observed());
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("[TB] FAIL reset_mid_post cycle %0d: got %h expected %h", cyc, observed(), expected());
            end
        end
    endtask

    initial begin
        test_reset();
        test_direction();
        test_pause();
        test_fire();
        test_hold();
        test_start();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
